// File: rtl/uart_rx_fifo_pkg.sv
// Shared definitions for the UART receive path: byte width and default rx FIFO sizing.
package uart_rx_fifo_pkg;

  localparam int unsigned BYTE_WIDTH      = 8;
  localparam int unsigned FIFO_DEPTH_LOG2 = 4;

  function automatic int unsigned fifo_depth(input int unsigned depth_log2);
    return 32'd1 << depth_log2;
  endfunction

endpackage

// File: rtl/uart_rx_fifo_rise_detect.sv
// Registered 1-bit rising-edge detector; RESET_VAL seeds the history so a level
// already high at reset release can be treated as "seen" (no edge).
module rise_detect #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_level,
  output logic o_rise
);

  logic r_prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prev <= RESET_VAL;
    end else begin
      r_prev <= i_level;
    end
  end

  assign o_rise = i_level & ~r_prev;

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive-side FWFT FIFO behind the UART receiver: one entry per rxDone rise,
// tagged with rxErr, with a sticky overflow flag for dropped bytes.
module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = FIFO_DEPTH_LOG2,
  parameter int unsigned DATA_WIDTH = BYTE_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rxDone,
  input  logic                  rxErr,
  input  logic [DATA_WIDTH-1:0] rxByte,
  input  logic                  rdEn,
  input  logic                  clrOverflow,
  output logic [DATA_WIDTH-1:0] rdData,
  output logic                  rdErr,
  output logic                  empty,
  output logic                  full,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow
);

  localparam int unsigned DEPTH = fifo_depth(DEPTH_LOG2);
  localparam logic [DEPTH_LOG2:0]   COUNT_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0]   COUNT_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

  logic [DATA_WIDTH:0]   r_mem [0:DEPTH-1];
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_count;
  logic                  r_overflow;

  logic                  w_wr_req;
  logic                  w_rd_req;
  logic                  w_wr_ok;
  logic                  w_empty;
  logic                  w_full;
  logic [DATA_WIDTH:0]   w_head;

  rise_detect #(
    .RESET_VAL (1'b1)
  ) u_done_rise (
    .clk     (clk),
    .rst     (reset),
    .i_level (rxDone),
    .o_rise  (w_wr_req)
  );

  assign w_empty  = (r_count == '0);
  assign w_full   = (r_count == COUNT_FULL);
  assign w_rd_req = rdEn & ~w_empty;
  // A read in the same cycle frees the slot, so a full FIFO still accepts the write.
  assign w_wr_ok  = w_wr_req & (~w_full | w_rd_req);

  always_ff @(posedge clk) begin
    if (w_wr_ok) begin
      r_mem[r_wr_ptr] <= {rxErr, rxByte};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr_ok) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_rd_req) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      case ({w_wr_ok, w_rd_req})
        2'b10:   r_count <= r_count + COUNT_ONE;
        2'b01:   r_count <= r_count - COUNT_ONE;
        default: r_count <= r_count;
      endcase
      // Set has priority over clear so a drop is never lost.
      if (w_wr_req & ~w_wr_ok) begin
        r_overflow <= 1'b1;
      end else if (clrOverflow) begin
        r_overflow <= 1'b0;
      end
    end
  end

  assign w_head   = r_mem[r_rd_ptr];
  assign rdData   = w_empty ? '0 : w_head[DATA_WIDTH-1:0];
  assign rdErr    = w_empty ? 1'b0 : w_head[DATA_WIDTH];
  assign empty    = w_empty;
  assign full     = w_full;
  assign count    = r_count;
  assign overflow = r_overflow;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: a single-cycle vector table plus hand-written
// sequences for hold-high, fill/overflow, full-with-read and mid-stream reset.
module tb_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       reset;
  logic       rxDone;
  logic       rxErr;
  logic [7:0] rxByte;
  logic       rdEn;
  logic       clrOverflow;
  logic [7:0] rdData;
  logic       rdErr;
  logic       empty;
  logic       full;
  logic [4:0] count;
  logic       overflow;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  uart_rx_fifo #(
    .DEPTH_LOG2 (4),
    .DATA_WIDTH (8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .rxDone      (rxDone),
    .rxErr       (rxErr),
    .rxByte      (rxByte),
    .rdEn        (rdEn),
    .clrOverflow (clrOverflow),
    .rdData      (rdData),
    .rdErr       (rdErr),
    .empty       (empty),
    .full        (full),
    .count       (count),
    .overflow    (overflow)
  );

  typedef struct {
    logic       done;
    logic       err;
    logic [7:0] byte_in;
    logic       rd;
    logic       clr;
    logic [4:0] e_count;
    logic       e_empty;
    logic       e_full;
    logic [7:0] e_data;
    logic       e_err;
    logic       e_ovf;
  } vec_t;

  vec_t vecs [13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] snap();
    return {15'd0, count, empty, full, rdData, rdErr, overflow};
  endfunction

  function automatic logic [31:0] pack(input logic [4:0] c, input logic e, input logic f,
                                       input logic [7:0] d, input logic er, input logic o);
    return {15'd0, c, e, f, d, er, o};
  endfunction

  task automatic push(input logic [7:0] b, input logic e);
    @(negedge clk);
    rxByte = b;
    rxErr  = e;
    rxDone = 1'b1;
    @(negedge clk);
    rxDone = 1'b0;
  endtask

  task automatic pop();
    @(negedge clk);
    rdEn = 1'b1;
    @(negedge clk);
    rdEn = 1'b0;
  endtask

  initial begin
    reset       = 1'b1;
    rxDone      = 1'b1;
    rxErr       = 1'b0;
    rxByte      = 8'h11;
    rdEn        = 1'b0;
    clrOverflow = 1'b0;

    //           done err byte   rd clr  cnt emp full data  err ovf
    vecs[0]  = '{1'b1, 1'b0, 8'h11, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 8'h35, 1'b0, 1'b0, 5'd1, 1'b0, 1'b0, 8'h35, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 8'h99, 1'b0, 1'b0, 5'd1, 1'b0, 1'b0, 8'h35, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 5'd1, 1'b0, 1'b0, 8'h35, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 1'b1, 8'h3C, 1'b0, 1'b0, 5'd2, 1'b0, 1'b0, 8'h35, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 5'd1, 1'b0, 1'b0, 8'h3C, 1'b1, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 8'h77, 1'b1, 1'b0, 5'd1, 1'b0, 1'b0, 8'h77, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 8'h5A, 1'b1, 1'b0, 5'd1, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 5'd0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};

    repeat (3) @(posedge clk);
    #1 check("reset_state", snap(), pack(5'd0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0));
    @(negedge clk);
    reset = 1'b0;

    // rxDone already high at reset release must never be captured
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1 check("idle", snap(), pack(5'd0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0));
    end

    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      rxDone      = vecs[i].done;
      rxErr       = vecs[i].err;
      rxByte      = vecs[i].byte_in;
      rdEn        = vecs[i].rd;
      clrOverflow = vecs[i].clr;
      @(posedge clk);
      #1 check($sformatf("vec%0d", i), snap(),
               pack(vecs[i].e_count, vecs[i].e_empty, vecs[i].e_full,
                    vecs[i].e_data, vecs[i].e_err, vecs[i].e_ovf));
    end
    @(negedge clk);
    rdEn        = 1'b0;
    clrOverflow = 1'b0;

    // Long rxDone pulse yields one entry
    rxByte = 8'hA5;
    rxErr  = 1'b0;
    rxDone = 1'b1;
    repeat (50) @(negedge clk);
    rxDone = 1'b0;
    @(negedge clk);
    check("hold_count", 32'(count), 32'd1);
    check("hold_data", 32'(rdData), 32'hA5);
    pop();
    check("hold_empty", 32'(empty), 32'd1);

    // Fill, drop with concurrent clear (set wins), drain in order, clear
    for (int i = 0; i < 16; i++) push(8'(i), 1'b0);
    check("fill_full", {count, full, overflow}, {5'd16, 1'b1, 1'b0});
    @(negedge clk);
    rxByte      = 8'hFF;
    rxDone      = 1'b1;
    clrOverflow = 1'b1;
    @(negedge clk);
    rxDone      = 1'b0;
    clrOverflow = 1'b0;
    check("drop", {count, full, overflow}, {5'd16, 1'b1, 1'b1});
    for (int i = 0; i < 16; i++) begin
      check($sformatf("drain%0d", i), 32'(rdData), 32'(i));
      pop();
    end
    check("drained", {count, empty, overflow}, {5'd0, 1'b1, 1'b1});
    @(negedge clk);
    clrOverflow = 1'b1;
    @(negedge clk);
    clrOverflow = 1'b0;
    check("ovf_clr", 32'(overflow), 32'd0);

    // Full FIFO, write and read in the same cycle
    for (int i = 0; i < 16; i++) push(8'h10 + 8'(i), 1'b0);
    @(negedge clk);
    rxByte = 8'hEE;
    rxDone = 1'b1;
    rdEn   = 1'b1;
    @(negedge clk);
    rxDone = 1'b0;
    rdEn   = 1'b0;
    check("full_rw", {count, full, overflow}, {5'd16, 1'b1, 1'b0});
    for (int i = 0; i < 16; i++) begin
      check($sformatf("full_rw_order%0d", i), 32'(rdData),
            (i == 15) ? 32'hEE : 32'h11 + 32'(i));
      pop();
    end
    check("full_rw_empty", 32'(empty), 32'd1);

    // Error-tagged byte, then asynchronous reset with 5 entries
    push(8'h3C, 1'b1);
    for (int i = 0; i < 4; i++) push(8'h40 + 8'(i), 1'b0);
    check("err_entry", {count, rdData, rdErr}, {5'd5, 8'h3C, 1'b1});
    @(posedge clk);
    #2 reset = 1'b1;
    #1 check("async_reset", snap(), pack(5'd0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0));
    @(negedge clk);
    reset = 1'b0;
    push(8'h66, 1'b0);
    check("post_reset", {count, rdData}, {5'd1, 8'h66});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
